// File: rtl/addr_decoder.sv
// Serial slave-address decoder: shifts in the slave ID, checks readiness, then
// holds the connection and steers the master's valid strobe to the chosen slave.
module addr_decoder #(
    parameter int SLAVE_ID_BITS = 2,
    parameter int NUM_SLAVES    = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mvalid,
    input  logic                     mdata,
    input  logic                     trans_done,
    input  logic [NUM_SLAVES-1:0]    sready,
    output logic [NUM_SLAVES-1:0]    mvalid_out,
    output logic [SLAVE_ID_BITS-1:0] sel,
    output logic                     ack,
    output logic                     nack,
    output logic                     busy
);

    localparam int CW = $clog2(SLAVE_ID_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SLAVE_ID_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_CONNECT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SLAVE_ID_BITS-1:0] shift_q, shift_d;
    logic [SLAVE_ID_BITS-1:0] sel_q, sel_d;
    logic                     ack_q, ack_d;
    logic                     nack_q, nack_d;

    logic [SLAVE_ID_BITS:0]   id_full_s;
    logic [SLAVE_ID_BITS-1:0] id_s;
    logic                     grant_ok_s;
    logic                     eval_s;

    // An ID is grantable only if it names an attached slave that is ready.
    function automatic logic slave_ok(input logic [SLAVE_ID_BITS-1:0] id,
                                      input logic [NUM_SLAVES-1:0]    rdy);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            ok = ok | (rdy[i] & (int'(id) == i));
        end
        return ok;
    endfunction

    assign id_full_s  = {shift_q, mdata};
    assign id_s       = id_full_s[SLAVE_ID_BITS-1:0];
    assign grant_ok_s = slave_ok(id_s, sready);

    // Next-state, ID shifting and grant/refuse decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sel_d   = sel_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        eval_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mvalid) begin
                    if (SLAVE_ID_BITS == 1) begin
                        eval_s = 1'b1;
                    end else begin
                        shift_d = id_s;
                        cnt_d   = CW'(1);
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (trans_done) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = S_IDLE;
                end else if (mvalid) begin
                    if (cnt_q == LAST_CNT) begin
                        eval_s = 1'b1;
                    end else begin
                        shift_d = id_s;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_CONNECT: begin
                if (trans_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CONNECT;
                end
            end
            default: begin
                cnt_d   = '0;
                shift_d = '0;
                state_d = S_IDLE;
            end
        endcase
        // sel only moves on a grant so mux3 stays stable for late responses.
        if (eval_s) begin
            cnt_d   = '0;
            shift_d = '0;
            if (grant_ok_s) begin
                sel_d   = id_s;
                ack_d   = 1'b1;
                state_d = S_CONNECT;
            end else begin
                nack_d  = 1'b1;
                state_d = S_IDLE;
            end
        end else begin
            eval_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
        end
    end

    assign mvalid_out = (state_q == S_CONNECT) ? (NUM_SLAVES'(mvalid) << sel_q) : '0;
    assign sel        = sel_q;
    assign ack        = ack_q;
    assign nack       = nack_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_addr_decoder.sv
// Bench for addr_decoder: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_addr_decoder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       mvalid;
    logic       mdata;
    logic       trans_done;
    logic [2:0] sready;
    logic [2:0] mvalid_out;
    logic [1:0] sel;
    logic       ack;
    logic       nack;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model: number of ID bits gathered, their value, connection and grant flags.
    bit m_conn = 1'b0;
    int m_n    = 0;
    int m_id   = 0;
    int m_sel  = 0;
    bit m_ack  = 1'b0;
    bit m_nack = 1'b0;

    addr_decoder #(.SLAVE_ID_BITS(2), .NUM_SLAVES(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mvalid     (mvalid),
        .mdata      (mdata),
        .trans_done (trans_done),
        .sready     (sready),
        .mvalid_out (mvalid_out),
        .sel        (sel),
        .ack        (ack),
        .nack       (nack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the decoder.
    always begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_conn = 1'b0; m_n = 0; m_id = 0; m_sel = 0; m_ack = 1'b0; m_nack = 1'b0;
        end else begin
            m_ack  = 1'b0;
            m_nack = 1'b0;
            if (m_conn) begin
                if (trans_done) m_conn = 1'b0;
            end else if (m_n > 0 && trans_done) begin
                m_n = 0; m_id = 0;
            end else if (mvalid) begin
                m_id = m_id * 2 + int'(mdata);
                m_n  = m_n + 1;
                if (m_n == 2) begin
                    if (m_id < 3 && sready[m_id] == 1'b1) begin
                        m_sel = m_id; m_ack = 1'b1; m_conn = 1'b1;
                    end else begin
                        m_nack = 1'b1;
                    end
                    m_n = 0; m_id = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        int exp_mv;
        exp_mv = (m_conn && mvalid) ? (1 << m_sel) : 0;
        chk("m_sel",        int'(sel),        m_sel);
        chk("m_ack",        int'(ack),        int'(m_ack));
        chk("m_nack",       int'(nack),       int'(m_nack));
        chk("m_busy",       int'(busy),       int'(m_conn || m_n > 0));
        chk("m_mvalid_out", int'(mvalid_out), exp_mv);
    end

    task automatic cyc(input logic mv, input logic md, input logic td);
        @(posedge clk);
        #1;
        mvalid     = mv;
        mdata      = md;
        trans_done = td;
    endtask

    initial begin
        rstn = 1'b0; mvalid = 1'b0; mdata = 1'b0; trans_done = 1'b0; sready = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_mvalid_out", int'(mvalid_out), 0);
        rstn = 1'b1;

        // id=2 granted, strobes forwarded only to slave 2
        sready = 3'b111;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_ack", int'(ack), 1);
        chk("t2_nack", int'(nack), 0);
        chk("t2_sel", int'(sel), 2);
        chk("t2_busy", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, k[0], 1'b0);
            #1;
            chk("t2_fwd", int'(mvalid_out), 4);
            if (k == 0) chk("t2_ack_once", int'(ack), 0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_done_busy", int'(busy), 0);

        // id=3 refused, sel untouched
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_nack", int'(nack), 1);
        chk("t3_ack", int'(ack), 0);
        chk("t3_sel", int'(sel), 2);
        chk("t3_busy", int'(busy), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_nack_once", int'(nack), 0);

        // id=1 refused when slave 1 not ready, granted when it is
        sready = 3'b101;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_nack", int'(nack), 1);
        chk("t4_sel_kept", int'(sel), 2);
        sready = 3'b010;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_ack", int'(ack), 1);
        chk("t4_sel", int'(sel), 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t4_done_busy", int'(busy), 0);

        // stalls between ID bits
        sready = 3'b111;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_stall_busy", int'(busy), 1);
        chk("t5_stall_ack", int'(ack), 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t5_pre_ack", int'(ack), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_ack", int'(ack), 1);
        chk("t5_sel", int'(sel), 1);

        // asynchronous reset mid-connection
        cyc(1'b1, 1'b1, 1'b0);
        #1;
        chk("t1_fwd", int'(mvalid_out), 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t1_sel", int'(sel), 0);
        chk("t1_mvalid_out", int'(mvalid_out), 0);
        chk("t1_ack", int'(ack), 0);
        chk("t1_nack", int'(nack), 0);
        chk("t1_busy", int'(busy), 0);
        mvalid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // abort after the first ID bit, then a fresh id=0
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ack", int'(ack), 0);
        chk("t6_nack", int'(nack), 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_ack2", int'(ack), 1);
        chk("t6_sel", int'(sel), 0);

        // trans_done in IDLE does not block a new capture
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t7_ack", int'(ack), 1);
        chk("t7_sel", int'(sel), 2);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
